// File: rtl/led_cmd_tx_pkg.sv
// Shared types and constants for the LED command transmitter.
package led_cmd_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam logic [7:0]  CMD_BASE   = 8'h31;
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned NUM_REQ    = 4;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: accepts one byte per valid/ready handshake, LSB first, idle high.
module uart_tx_core
   import led_cmd_tx_pkg::*;
#(
   parameter int unsigned DIV = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready_c,
   output logic       active_c,
   output logic       tx
);

   localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              baud_last;

   assign baud_last = (baud_q == BAUD_W'(DIV - 1));

   // Next-state logic; tx is registered alongside the state transition.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      in_ready_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               shift_d = in_data;
               baud_d  = '0;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d     = '0;
               in_ready_c = 1'b1;
               if (in_valid) begin
                  shift_d = in_data;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign active_c = (state_q != IDLE);
   assign tx       = tx_q;

endmodule

// File: rtl/led_cmd_tx.sv
// Request edge detection, pending merge and command queue feeding the UART serializer.
module led_cmd_tx
   import led_cmd_tx_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_HZ = 80000000,
   parameter int unsigned BAUD_RATE     = 4000000,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [3:0]                      req,
   output logic                            tx,
   output logic                            busy,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int unsigned DIV   = CLOCK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [NUM_REQ-1:0] req_prev_q, pending_q, pending_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [7:0]         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;

   logic [NUM_REQ-1:0] edges, clr_mask;
   logic [1:0]         k;
   logic               full, push, pop, core_ready, core_active;
   logic [7:0]         cmd;

   assign edges = req & ~req_prev_q;
   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign push  = (|pending_q) && !full;
   assign pop   = (level_q != '0) && core_ready;
   assign cmd   = CMD_BASE + 8'(k);

   // Lowest set pending index wins the single write slot.
   always_comb begin
      k = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pending_q[i]) k = 2'(i);
      end
   end

   always_comb begin
      clr_mask   = push ? (NUM_REQ'(1) << k) : '0;
      // A fresh edge on the bit being drained this cycle is not a loss.
      pending_d  = (pending_q & ~clr_mask) | edges;
      overflow_d = overflow_q | (|(edges & pending_q & ~clr_mask));
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = cmd;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_q <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         req_prev_q <= req;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         mem_q      <= mem_d;
      end
   end

   uart_tx_core #(.DIV(DIV)) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (level_q != '0),
      .in_data    (mem_q[rd_ptr_q]),
      .in_ready_c (core_ready),
      .active_c   (core_active),
      .tx         (tx)
   );

   assign busy       = core_active || (level_q != '0) || (|pending_q);
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_led_cmd_tx.sv
// Directed bench for led_cmd_tx with a UART frame monitor on tx.
module tb_led_cmd_tx;

   localparam int DIV = 20;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       tx;
   logic       busy;
   logic       overflow;
   logic [2:0] fifo_level;

   int checks = 0;
   int errors = 0;

   led_cmd_tx #(
      .CLOCK_FREQ_HZ (80000000),
      .BAUD_RATE     (4000000),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Frame monitor state
   logic [7:0] rx_q[$];
   int         starts[$];
   int         busy_cnt = 0;
   int         peak     = 0;
   int         glitch   = 0;
   bit         in_frame = 0;
   int         fcnt     = 0;
   logic       cur_bit;
   logic [7:0] shreg;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 0;
      end else begin
         if (busy) busy_cnt++;
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         if (!in_frame && tx == 1'b0) begin
            in_frame = 1;
            fcnt     = 0;
            shreg    = '0;
            starts.push_back(cyc);
         end
         if (in_frame) begin
            if (fcnt % DIV == 0) cur_bit = tx;
            else if (tx != cur_bit) glitch++;
            if (fcnt % DIV == DIV / 2) begin
               if (fcnt / DIV == 0 && tx != 1'b0) glitch++;
               else if (fcnt / DIV == 9 && tx != 1'b1) glitch++;
               else if (fcnt / DIV >= 1 && fcnt / DIV <= 8) shreg[fcnt / DIV - 1] = tx;
            end
            fcnt++;
            if (fcnt == 10 * DIV) begin
               in_frame = 0;
               rx_q.push_back(shreg);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] v);
      req = v;
      tick();
      req = 4'b0000;
   endtask

   task automatic clear_mon();
      rx_q.delete();
      starts.delete();
      busy_cnt = 0;
      peak     = 0;
      glitch   = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      clear_mon();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check({name, " idle_timeout"}, int'(busy), 0);
   endtask

   task automatic check_gaps(input string name);
      for (int i = 1; i < starts.size(); i++)
         check({name, " frame_gap"}, starts[i] - starts[i-1], 10 * DIV);
   endtask

   typedef struct {
      logic [3:0]       req;
      int               hold;
      int               n;
      logic [3:0][7:0]  bytes;
      int               busy_cycles;
   } vec_t;

   vec_t vecs[5];

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      repeat (2) tick();
      check("reset tx", int'(tx), 1);
      check("reset busy", int'(busy), 0);
      check("reset fifo_level", int'(fifo_level), 0);
      check("reset overflow", int'(overflow), 0);

      vecs[0] = '{req: 4'b0001, hold: 1,    n: 1, bytes: 32'h00000031, busy_cycles: 202};
      vecs[1] = '{req: 4'b1010, hold: 1,    n: 2, bytes: 32'h00003432, busy_cycles: 402};
      vecs[2] = '{req: 4'b1000, hold: 1000, n: 1, bytes: 32'h00000034, busy_cycles: 202};
      vecs[3] = '{req: 4'b1111, hold: 1,    n: 4, bytes: 32'h34333231, busy_cycles: 802};
      vecs[4] = '{req: 4'b0100, hold: 1,    n: 1, bytes: 32'h00000033, busy_cycles: 202};

      for (int v = 0; v < 5; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         do_reset();
         req = vecs[v].req;
         repeat (vecs[v].hold) tick();
         req = 4'b0000;
         wait_idle(3000, nm);
         check({nm, " nbytes"}, rx_q.size(), vecs[v].n);
         for (int b = 0; b < vecs[v].n && b < rx_q.size(); b++)
            check({nm, $sformatf(" byte%0d", b)}, int'(rx_q[b]), int'(vecs[v].bytes[b]));
         check({nm, " overflow"}, int'(overflow), 0);
         check({nm, " busy_cycles"}, busy_cnt, vecs[v].busy_cycles);
         check({nm, " bit_timing"}, glitch, 0);
         check({nm, " fifo_level_end"}, int'(fifo_level), 0);
         check_gaps(nm);
      end

      // Queue full plus a merged second edge on req[2]
      do_reset();
      pulse(4'b0001);
      repeat (10) tick();
      pulse(4'b1011);
      repeat (5) tick();
      pulse(4'b0001);
      repeat (5) tick();
      check("full fifo_level", int'(fifo_level), 4);
      pulse(4'b0100);
      repeat (3) tick();
      check("full no_overflow_yet", int'(overflow), 0);
      pulse(4'b0100);
      tick();
      check("full overflow", int'(overflow), 1);
      check("full level_held", int'(fifo_level), 4);
      wait_idle(3000, "full");
      check("full nbytes", rx_q.size(), 6);
      begin
         logic [7:0] exp_full [6];
         exp_full = '{8'h31, 8'h31, 8'h32, 8'h34, 8'h31, 8'h33};
         for (int b = 0; b < 6 && b < rx_q.size(); b++)
            check($sformatf("full byte%0d", b), int'(rx_q[b]), int'(exp_full[b]));
      end
      check("full peak_level", peak, 4);
      check("full overflow_sticky", int'(overflow), 1);
      check("full bit_timing", glitch, 0);
      check_gaps("full");

      // Reset in the middle of a frame with bytes queued
      do_reset();
      pulse(4'b0001);
      repeat (5) tick();
      pulse(4'b0110);
      begin
         int n;
         n = 0;
         while (!(in_frame && fcnt >= 90) && n < 400) begin
            tick();
            n++;
         end
         check("midrst reach_cycle90", int'(in_frame && fcnt >= 90), 1);
      end
      check("midrst level_before", int'(fifo_level), 2);
      check("midrst tx_low_before", int'(tx), 0);
      rst_n = 1'b0;
      #1;
      check("midrst tx", int'(tx), 1);
      check("midrst fifo_level", int'(fifo_level), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst overflow", int'(overflow), 0);
      repeat (3) tick();
      clear_mon();
      rst_n = 1'b1;
      repeat (500) tick();
      check("midrst frames_after", rx_q.size() + starts.size(), 0);
      check("midrst busy_after", busy_cnt, 0);
      check("midrst tx_after", int'(tx), 1);

      // req already high when reset releases counts as an edge
      rst_n = 1'b0;
      req   = 4'b0010;
      repeat (2) tick();
      clear_mon();
      rst_n = 1'b1;
      tick();
      check("relhigh busy", int'(busy), 1);
      wait_idle(3000, "relhigh");
      check("relhigh nbytes", rx_q.size(), 1);
      if (rx_q.size() > 0) check("relhigh byte", int'(rx_q[0]), 32'h32);
      req = 4'b0000;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_cmd_tx.md
LED_CMD_TX -- requirements
Module: led_cmd_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 80000000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 4000000, the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the command queue depth (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 4 bits: command requests, synchronous to clk; a rising edge on req[i] requests command byte 0x31+i.
REQ-007 SHALL have port tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in flight, the queue is non-empty, or a request is pending.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag indicating a lost request.
REQ-010 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current queue occupancy.

Function
REQ-011 SHALL compute DIV = CLOCK_FREQ_HZ/BAUD_RATE (integer, at least 2); every bit period SHALL last exactly DIV clk cycles.
REQ-012 SHALL detect a rising edge on req[i] as req[i]=1 with the previous-cycle sample 0, and SHALL set pending[i].
- A held-high req SHALL yield one request only.
REQ-013 An edge on req[i] while pending[i] is already set SHALL be merged, SHALL set overflow, and SHALL not queue a second byte.
REQ-014 Each cycle with pending non-zero and the queue not full SHALL write 0x31+k to the queue and clear pending[k], where k is the lowest set index.
- Exactly one write per cycle.
- A same-cycle new edge on index k SHALL re-set pending[k] without setting overflow.
REQ-015 With the queue full, pending bits SHALL hold; there SHALL be no write and no loss.
REQ-016 Transmit FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE: when the queue is non-empty, pop the head into the shift register and go to START; tx SHALL go low on the next cycle.
- START: tx=0 for DIV cycles, then DATA.
- DATA: bit 0 first, each bit for DIV cycles; after 8 bits go to STOP.
- STOP: tx=1 for DIV cycles. At its last cycle, if the queue is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-017 A frame SHALL occupy exactly 10*DIV cycles.
REQ-018 A queue write and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-019 Queue read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 busy SHALL equal (state!=IDLE) OR (fifo_level!=0) OR (pending!=0).
REQ-021 overflow SHALL be cleared only by reset.

Reset
REQ-022 rst_n low SHALL immediately force the following, mid-frame included:
- tx=1, state=IDLE;
- queue empty, fifo_level=0;
- pending=0, overflow=0, busy=0;
- baud and bit counters 0;
- previous req samples 0.
REQ-023 After rst_n rises, a req input already high SHALL count as a rising edge on the first clk edge.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enumeration;
- the command base constant 0x31;
- the frame length constant 10.
REQ-025 The serializer (FSM, baud counter, shift register) SHALL be one sub-module, uart_tx_core, with a valid/ready byte handshake.
REQ-026 The queue and pending logic SHALL live in led_cmd_tx.

Verification (DIV=20, FIFO_DEPTH=4)
REQ-027 Single pulse on req[0] -> one 200-cycle frame: tx = 0, then 1,0,0,0,1,1,0,0, then 1, each bit 20 cycles; busy falls after the stop bit.
REQ-028 req=4'b1010 applied in one cycle -> 0x32 then 0x34, back-to-back, 400 cycles total with no idle cycle between frames; overflow stays 0.
REQ-029 req[3] held high for 1000 cycles -> exactly one 0x34 frame.
REQ-030 Second edge on req[2] before its first edge is queued (queue held full by edges on 0,1,3 plus a frame in flight) -> overflow=1 and only one 0x33 is sent.
REQ-031 Seven distinct edge events while the first frame is sending -> fifo_level peaks at 4; all queued bytes are sent in lowest-index order with no byte lost.
REQ-032 rst_n asserted at cycle 90 of a frame -> tx=1 and fifo_level=0 in the same cycle; after release, no output until a new req edge.
